// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller and the door stage:
// car states, travel direction encoding and default sizing constants.
package elevator_pkg;

  localparam int DEF_FLOORS     = 8;
  localparam int DEF_TRAVEL_CYC = 16;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    ARRIVE,
    DOOR_OPENING,
    DOOR_WAIT
  } car_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

endpackage

// File: rtl/elev_travel_timer.sv
// One-floor travel timer: counts 0..TRAVEL_CYC-1 while start is high and
// pulses done on the last count; held at zero whenever start is low.
module elev_travel_timer #(
  parameter int CNT_W      = 5,
  parameter int TRAVEL_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TRAVEL_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign done = start && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!start || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: latches floor calls, moves one floor per
// TRAVEL_CYC cycles, stops at pending floors and handshakes with the door stage.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS     = DEF_FLOORS,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  req,
  input  logic               door_closed,
  output logic               door_open,
  output logic [FLOOR_W-1:0] floor,
  output logic [FLOORS-1:0]  pending,
  output logic               dir_up,
  output logic               dir_dn,
  output logic               busy
);

  car_state_t         state, state_d;
  dir_t               dir, dir_d;
  logic [FLOOR_W-1:0] floor_d, step_floor;
  logic [FLOORS-1:0]  pending_d, absorb, clr;
  logic [FLOORS-1:0]  above, below;
  logic               any_above, any_below, here, step_hit;
  logic               at_top, at_bot, door_phase, enter_arrive, tmr_done;

  elev_travel_timer #(
    .CNT_W      (CNT_W),
    .TRAVEL_CYC (TRAVEL_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == MOVE),
    .done  (tmr_done)
  );

  assign at_top     = (floor == FLOOR_W'(FLOORS - 1));
  assign at_bot     = (floor == '0);
  assign step_floor = (dir == DIR_DN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
  assign door_phase = state inside {ARRIVE, DOOR_OPENING, DOOR_WAIT};

  // Pending masks relative to the current floor and to the floor being stepped into.
  always_comb begin
    above    = '0;
    below    = '0;
    here     = 1'b0;
    step_hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above[i] = pending[i] && (FLOOR_W'(i) > floor);
      below[i] = pending[i] && (FLOOR_W'(i) < floor);
      here     = here     | (pending[i] && (FLOOR_W'(i) == floor));
      step_hit = step_hit | (pending[i] && (FLOOR_W'(i) == step_floor));
    end
  end

  assign any_above = |above;
  assign any_below = |below;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    floor_d      = floor;
    dir_d        = dir;
    enter_arrive = 1'b0;
    unique case (state)
      IDLE: begin
        dir_d = DIR_NONE;
        if (here) begin
          state_d      = ARRIVE;
          enter_arrive = 1'b1;
        end else if (any_above) begin
          state_d = MOVE;
          dir_d   = DIR_UP;
        end else if (any_below) begin
          state_d = MOVE;
          dir_d   = DIR_DN;
        end
      end
      MOVE: begin
        if (tmr_done) begin
          if ((dir == DIR_UP && !at_top) || (dir == DIR_DN && !at_bot)) begin
            floor_d = step_floor;
            if (step_hit) begin
              state_d      = ARRIVE;
              enter_arrive = 1'b1;
            end
          end else begin
            // Only reachable if travel was started with nothing ahead.
            state_d = IDLE;
            dir_d   = DIR_NONE;
          end
        end
      end
      ARRIVE: state_d = DOOR_OPENING;
      DOOR_OPENING: begin
        if (!door_closed) state_d = DOOR_WAIT;
      end
      DOOR_WAIT: begin
        if (door_closed) begin
          // Keep heading while calls lie ahead; a stop from IDLE prefers up.
          if (dir == DIR_DN && any_below) begin
            state_d = MOVE;
          end else if (dir != DIR_DN && any_above) begin
            state_d = MOVE;
            dir_d   = DIR_UP;
          end else if (any_below) begin
            state_d = MOVE;
            dir_d   = DIR_DN;
          end else if (any_above) begin
            state_d = MOVE;
            dir_d   = DIR_UP;
          end else begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_NONE;
      end
    endcase
  end

  // Calls at the served floor are absorbed while the doors cycle, and the
  // arrival clear wins over a call sampled on the same edge.
  always_comb begin
    absorb = '0;
    clr    = '0;
    for (int i = 0; i < FLOORS; i++) begin
      absorb[i] = door_phase && (FLOOR_W'(i) == floor);
      clr[i]    = enter_arrive && (FLOOR_W'(i) == floor_d);
    end
  end

  assign pending_d = (pending | (req & ~absorb)) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir     <= DIR_NONE;
      floor   <= '0;
      pending <= '0;
    end else begin
      state   <= state_d;
      dir     <= dir_d;
      floor   <= floor_d;
      pending <= pending_d;
    end
  end

  assign door_open = (state == ARRIVE);
  assign dir_up    = (dir == DIR_UP);
  assign dir_dn    = (dir == DIR_DN);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with TRAVEL_CYC=4: single call, door
// hold, same-floor call, pick-up en route, reversal, reset mid-move.
module tb_elevator_car_ctrl;

  localparam int FLOORS     = 8;
  localparam int FLOOR_W    = 3;
  localparam int TRAVEL_CYC = 4;
  localparam int CNT_W      = 5;

  logic               clk;
  logic               rst_n;
  logic [FLOORS-1:0]  req;
  logic               door_closed;
  logic               door_open;
  logic [FLOOR_W-1:0] floor;
  logic [FLOORS-1:0]  pending;
  logic               dir_up;
  logic               dir_dn;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  elevator_car_ctrl #(
    .FLOORS     (FLOORS),
    .FLOOR_W    (FLOOR_W),
    .TRAVEL_CYC (TRAVEL_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .door_closed (door_closed),
    .door_open   (door_open),
    .floor       (floor),
    .pending     (pending),
    .dir_up      (dir_up),
    .dir_dn      (dir_dn),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From the ARRIVE cycle: door opens, reports open, reports closed again.
  task automatic door_cycle();
    tick(1);
    door_closed = 1'b0;
    tick(1);
    door_closed = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    door_closed = 1'b1;
    tick(3);
    check("rst_floor",   floor,     0);
    check("rst_pending", pending,   0);
    check("rst_busy",    busy,      0);
    check("rst_door",    door_open, 0);
    check("rst_dir",     {dir_up, dir_dn}, 0);

    // Single call to floor 5; req presented for the first edge after reset.
    rst_n = 1'b1;
    req   = 8'h20;
    tick(1);
    check("a_pending_set", pending, 8'h20);
    check("a_still_idle",  busy,    0);
    req = '0;
    tick(1);
    check("a_move_busy",  busy,   1);
    check("a_move_dirup", {dir_up, dir_dn}, 2'b10);
    check("a_move_floor", floor,  0);
    tick(19);
    check("a_floor4",     floor,     4);
    check("a_no_door_4",  door_open, 0);
    tick(1);
    check("a_floor5",     floor,     5);
    check("a_door_open",  door_open, 1);
    check("a_pend_clr",   pending,   0);
    tick(1);
    check("a_door_pulse", door_open, 0);
    check("a_dir_held",   dir_up,    1);
    tick(10);
    check("a_hold_floor", floor,     5);
    check("a_hold_busy",  busy,      1);
    check("a_hold_door",  door_open, 0);
    door_closed = 1'b0;
    tick(1);
    door_closed = 1'b1;
    tick(1);
    check("a_idle_busy",  busy, 0);
    check("a_idle_dir",   {dir_up, dir_dn}, 0);

    // Travel down from 5 to 2.
    req = 8'h04;
    tick(1);
    req = '0;
    tick(1);
    check("b_dir_dn",  {dir_up, dir_dn}, 2'b01);
    tick(12);
    check("b_floor2",  floor,     2);
    check("b_door",    door_open, 1);
    door_cycle();
    check("b_idle",    busy, 0);
    check("b_dir_clr", {dir_up, dir_dn}, 0);

    // Same-floor call while idle at 2.
    req = 8'h04;
    tick(1);
    check("c_pending",   pending, 8'h04);
    req = '0;
    tick(1);
    check("c_arrive",    door_open, 1);
    check("c_floor",     floor,     2);
    check("c_no_dir",    {dir_up, dir_dn}, 0);
    check("c_pend_clr",  pending,   0);
    door_cycle();
    check("c_idle",      busy,  0);
    check("c_floor_end", floor, 2);

    // Up to 6, pick up 4 en route (held as a level through the stop), then 1 behind.
    req = 8'h40;
    tick(1);
    req = '0;
    tick(2);
    req = 8'h10;
    tick(1);
    check("d_pend_two", pending, 8'h50);
    check("d_floor2",   floor,   2);
    tick(6);
    check("d_stop4",      floor,     4);
    check("d_door4",      door_open, 1);
    check("d_no_reset_4", pending,   8'h40);
    tick(1);
    door_closed = 1'b0;
    check("d_absorb_4",   pending,   8'h40);
    tick(1);
    door_closed = 1'b1;
    tick(1);
    req = '0;
    check("d_resume_up",  {dir_up, dir_dn}, 2'b10);
    check("d_resume_busy", busy, 1);
    req = 8'h02;
    tick(1);
    check("d_pend_6_1",   pending, 8'h42);
    check("d_floor4_mv",  floor,   4);
    req = '0;
    tick(7);
    check("d_floor6",     floor,     6);
    check("d_door6",      door_open, 1);
    check("d_left_1",     pending,   8'h02);
    door_cycle();
    check("d_reverse",    {dir_up, dir_dn}, 2'b01);
    check("d_rev_busy",   busy, 1);
    tick(12);
    check("d_desc_3",     floor,  3);
    check("d_desc_dn",    dir_dn, 1);
    tick(8);
    check("d_floor1",     floor,     1);
    check("d_door1",      door_open, 1);
    check("d_pend_empty", pending,   0);
    check("d_dn_held",    dir_dn,    1);
    door_cycle();
    check("d_idle",       busy, 0);

    // Reset mid-move at floor 3 while heading to 7.
    req = 8'h80;
    tick(1);
    req = '0;
    tick(9);
    check("e_floor3",  floor, 3);
    check("e_busy",    busy,  1);
    #3;
    rst_n = 1'b0;
    #1;
    check("e_rst_floor", floor,     0);
    check("e_rst_pend",  pending,   0);
    check("e_rst_busy",  busy,      0);
    check("e_rst_dir",   {dir_up, dir_dn}, 0);
    check("e_rst_door",  door_open, 0);
    tick(1);
    rst_n = 1'b1;
    req   = 8'h02;
    tick(1);
    check("e_first_req", pending, 8'h02);
    check("e_discarded", busy,    0);
    req = '0;
    tick(1);
    check("e_move_up",   {dir_up, dir_dn}, 2'b10);
    tick(4);
    check("e_floor1",    floor,     1);
    check("e_door1",     door_open, 1);
    check("e_pend_clr",  pending,   0);
    door_cycle();

    // Down to the bottom floor.
    req = 8'h01;
    tick(1);
    req = '0;
    tick(1);
    check("f_dir_dn",  {dir_up, dir_dn}, 2'b01);
    tick(4);
    check("f_floor0",  floor,     0);
    check("f_door0",   door_open, 1);
    door_cycle();
    check("f_idle",    busy,  0);
    check("f_floor_end", floor, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
